// File: rtl/synth_slot_sequencer.sv
// Frame sequencer for a voice/oscillator/envelope synth engine: steps once through
// every {voice, osc, env} slot per frame and emits slot strobes plus a delayed copy.
module synth_slot_sequencer #(
    parameter int VOICES     = 32,
    parameter int V_OSC      = 8,
    parameter int O_ENVS     = 2,
    parameter int SLOT_CYC   = 2,
    parameter int PIPE_DEPTH = 4,
    parameter int V_WIDTH    = (VOICES > 1) ? $clog2(VOICES) : 1,
    parameter int O_WIDTH    = (V_OSC > 1) ? $clog2(V_OSC) : 1,
    parameter int OE_WIDTH   = (O_ENVS > 1) ? $clog2(O_ENVS) : 1,
    parameter int E_WIDTH    = O_WIDTH + OE_WIDTH,
    parameter int X_WIDTH    = V_WIDTH + E_WIDTH
) (
    input  logic               AUDIO_CLK,
    input  logic               reset_reg,
    input  logic               trig,
    input  logic               enable,
    input  logic               ovr_clr,
    output logic [X_WIDTH-1:0] xxxx,
    output logic               sCLK_XVXENVS,
    output logic               sCLK_XVXOSC,
    output logic               xxxx_zero,
    output logic               run,
    output logic               frame_done,
    output logic [X_WIDTH-1:0] xxxx_dly,
    output logic               envs_dly,
    output logic               overrun,
    output logic [7:0]         missed_trig
);

    localparam int S_WIDTH = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
    localparam logic [S_WIDTH-1:0]  SLOT_LAST  = S_WIDTH'(SLOT_CYC - 1);
    localparam logic [OE_WIDTH-1:0] ENV_LAST   = OE_WIDTH'(O_ENVS - 1);
    localparam logic [O_WIDTH-1:0]  OSC_LAST   = O_WIDTH'(V_OSC - 1);
    localparam logic [V_WIDTH-1:0]  VOICE_LAST = V_WIDTH'(VOICES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [S_WIDTH-1:0]  slot_reg, slot_next;
    logic [OE_WIDTH-1:0] env_reg, env_next;
    logic [O_WIDTH-1:0]  osc_reg, osc_next;
    logic [V_WIDTH-1:0]  voice_reg, voice_next;
    logic                pending_reg, pending_next;
    logic                overrun_reg, overrun_next;
    logic [7:0]          missed_reg, missed_next;
    logic                run_reg, run_next;
    logic                done_reg, done_next;
    logic                envs_reg, envs_next;
    logic                osc_strb_reg, osc_strb_next;
    logic                zero_reg, zero_next;
    logic                advance;
    logic                ov_event;

    logic [X_WIDTH-1:0]  xpipe_reg [PIPE_DEPTH];
    logic                epipe_reg [PIPE_DEPTH];

    always_ff @(posedge AUDIO_CLK) begin
        if (reset_reg) begin
            state_reg    <= IDLE;
            slot_reg     <= '0;
            env_reg      <= '0;
            osc_reg      <= '0;
            voice_reg    <= '0;
            pending_reg  <= 1'b0;
            overrun_reg  <= 1'b0;
            missed_reg   <= 8'd0;
            run_reg      <= 1'b0;
            done_reg     <= 1'b0;
            envs_reg     <= 1'b0;
            osc_strb_reg <= 1'b0;
            zero_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            slot_reg     <= slot_next;
            env_reg      <= env_next;
            osc_reg      <= osc_next;
            voice_reg    <= voice_next;
            pending_reg  <= pending_next;
            overrun_reg  <= overrun_next;
            missed_reg   <= missed_next;
            run_reg      <= run_next;
            done_reg     <= done_next;
            envs_reg     <= envs_next;
            osc_strb_reg <= osc_strb_next;
            zero_reg     <= zero_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        slot_next    = slot_reg;
        env_next     = env_reg;
        osc_next     = osc_reg;
        voice_next   = voice_reg;
        pending_next = pending_reg;
        overrun_next = overrun_reg;
        missed_next  = missed_reg;
        advance      = 1'b0;
        ov_event     = (state_reg != IDLE) && trig && pending_reg;

        unique case (state_reg)
            IDLE: begin
                if (trig || pending_reg) begin
                    state_next   = SWEEP;
                    slot_next    = '0;
                    env_next     = '0;
                    osc_next     = '0;
                    voice_next   = '0;
                    pending_next = 1'b0;
                    advance      = 1'b1;
                end
            end
            SWEEP: begin
                if (trig && !pending_reg) begin
                    pending_next = 1'b1;
                end
                if (enable) begin
                    advance = 1'b1;
                    // Nested carry chain: slot cycle -> env -> osc -> voice -> frame end.
                    if (slot_reg == SLOT_LAST) begin
                        slot_next = '0;
                        if (env_reg == ENV_LAST) begin
                            env_next = '0;
                            if (osc_reg == OSC_LAST) begin
                                osc_next = '0;
                                if (voice_reg == VOICE_LAST) begin
                                    voice_next = '0;
                                    state_next = DONE;
                                end else begin
                                    voice_next = voice_reg + 1'b1;
                                end
                            end else begin
                                osc_next = osc_reg + 1'b1;
                            end
                        end else begin
                            env_next = env_reg + 1'b1;
                        end
                    end else begin
                        slot_next = slot_reg + 1'b1;
                    end
                end
            end
            DONE: begin
                if (trig && !pending_reg) begin
                    pending_next = 1'b1;
                end
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A coincident overrun outranks a clear so the event is never lost.
        if (ov_event) begin
            overrun_next = 1'b1;
            if (ovr_clr) begin
                missed_next = 8'd1;
            end else if (missed_reg != 8'hFF) begin
                missed_next = missed_reg + 8'd1;
            end
        end else if (ovr_clr) begin
            overrun_next = 1'b0;
            missed_next  = 8'd0;
        end

        run_next      = (state_next == SWEEP);
        done_next     = (state_next == DONE);
        envs_next     = run_next && advance && (slot_next == '0);
        osc_strb_next = envs_next && (env_next == '0);
        zero_next     = run_next && ({voice_next, osc_next, env_next} == X_WIDTH'(0));
    end

    // Delay taps shift every clock, independent of the sweep enable.
    always_ff @(posedge AUDIO_CLK) begin
        if (reset_reg) begin
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                xpipe_reg[i] <= '0;
                epipe_reg[i] <= 1'b0;
            end
        end else begin
            xpipe_reg[0] <= xxxx;
            epipe_reg[0] <= envs_reg;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                xpipe_reg[i] <= xpipe_reg[i-1];
                epipe_reg[i] <= epipe_reg[i-1];
            end
        end
    end

    assign xxxx[X_WIDTH-1:E_WIDTH] = voice_reg;
    assign xxxx[E_WIDTH-1:0]       = {osc_reg, env_reg};
    assign sCLK_XVXENVS            = envs_reg;
    assign sCLK_XVXOSC             = osc_strb_reg;
    assign xxxx_zero               = zero_reg;
    assign run                     = run_reg;
    assign frame_done              = done_reg;
    assign overrun                 = overrun_reg;
    assign missed_trig             = missed_reg;
    assign xxxx_dly                = xpipe_reg[PIPE_DEPTH-1];
    assign envs_dly                = epipe_reg[PIPE_DEPTH-1];

endmodule
